wb_port_arbiter: RTL and testbench
==================================

// Module: wb_port_arbiter
// PURPOSE
// - Shares the single register-file write port between the in-order MEM/WB result (pipe requester)
//   and the long-latency result path (LL requester: mul/div, late load data).
// - Selects the write-back source each cycle, buffers LL results in a small FIFO and prevents LL starvation.
// - Drives the registered register-file write (we/rd/data) that sits after the MEM/WB data select.
// PARAMETERS
// - XLEN       32  data width of write-back values
// - LL_DEPTH   2   LL result FIFO entries (power of 2, >=2)
// - STARVE_MAX 4   consecutive pipe grants tolerated while LL head waits (>=1)
// PORTS
// - clk        in   1     core clock, all state on rising edge
// - rst_n      in   1     asynchronous active-low reset
// - pipe_valid in   1     MEM/WB holds a writing instruction this cycle
// - pipe_rd    in   5     destination register of pipe result
// - pipe_data  in   XLEN  selected write-back value (mem data or ALU out)
// - pipe_stall out  1     hold MEM/WB this cycle; pipe result not consumed
// - ll_valid   in   1     LL result offered
// - ll_rd      in   5     LL destination register
// - ll_data    in   XLEN  LL result value
// - ll_ready   out  1     LL result accepted when ll_valid & ll_ready
// - rf_we      out  1     register-file write enable (registered)
// - rf_rd      out  5     register-file write address (registered)
// - rf_wdata   out  XLEN  register-file write data (registered)
// BEHAVIOUR
// - Reset (async assert, sync release): FIFO empty, starve_cnt=0, state=PIPE_PRIO,
//   rf_we=0, rf_rd=0, rf_wdata=0; ll_ready=1 and pipe_stall=0 while in reset state.
// - ll_ready = !fifo_full (registered count only); push on ll_valid & ll_ready. No bypass: an entry
//   pushed in cycle N is poppable earliest in N+1, so rf_we for it is visible earliest at edge N+2.
// - FSM PIPE_PRIO: pipe_valid -> grant pipe; else FIFO non-empty -> pop and grant LL.
//   starve_cnt++ on each cycle with pipe granted and FIFO non-empty; cleared on any LL grant
//   or FIFO empty. starve_cnt reaching STARVE_MAX -> next state FORCE_LL.
// - FSM FORCE_LL (exactly one cycle): pop and grant LL; pipe_stall = pipe_valid; -> PIPE_PRIO, starve_cnt=0.
// - pipe_stall is a function of registered state and pipe_valid only; no path from ll_* to pipe_stall.
// - Grant with rd==0: request consumed (pop/no stall) but rf_we=0 next cycle (x0 never written).
// - Write latency: granted request appears on rf_we/rf_rd/rf_wdata after exactly 1 clock.
//   No grant -> rf_we=0 next cycle; rf_rd/rf_wdata hold last values.
// - Simultaneous push and pop: both performed; count unchanged. Push when full: ignored (ll_ready=0).
// - Pointers wrap modulo LL_DEPTH; count is $clog2(LL_DEPTH)+1 bits.
// - Reset mid-operation: FIFO contents discarded, any in-flight rf_we dropped immediately.
// - LL results carry no ordering guarantee vs pipe results; hazard tracking is done upstream.
// CONFIGURATION
// - WB_ARB_FWD_EN defined: extra outputs fwd_valid/fwd_rd/fwd_data mirror rf_we/rf_rd/rf_wdata
//   (same cycle) for the EX forwarding unit; fwd_valid=0 when rf_rd==0.
// - WB_ARB_FWD_EN undefined: ports absent; no forwarding logic synthesised.
// STRUCTURE
// - Package wb_pkg: typedef wb_req_t {logic [4:0] rd; logic [XLEN-1:0] data;},
//   enum wb_arb_state_e {PIPE_PRIO, FORCE_LL}, constant REG_X0 = 5'd0.
// - Sub-module wb_ll_fifo: sync FIFO of wb_req_t, LL_DEPTH entries, push/pop/full/empty, async reset.
// - Top holds FSM, starvation counter, grant mux and output register.
// TESTING
// - Pipe only: pipe_valid=1 rd=5 data=0xDEADBEEF -> next cycle rf_we=1 rf_rd=5 rf_wdata=0xDEADBEEF.
// - x0 write: pipe_valid=1 rd=0 data=0x1234 -> pipe_stall=0, next cycle rf_we=0.
// - LL idle path: pipe idle, LL push rd=7 data=0x55 at edge N -> rf_we=1 rf_rd=7 after edge N+2.
// - Starvation: STARVE_MAX=4, pipe_valid held 1, one LL entry -> 4 pipe writes, then 1 cycle
//   pipe_stall=1 with LL write, then pipe writes resume; held pipe value written once.
// - Full: LL_DEPTH=2, pipe saturating, 3 LL offers -> ll_ready=0 on third, no entry lost or duplicated.
// - Reset mid-op: FIFO holds 2 entries, rst_n low 1 cycle -> rf_we=0 at once, ll_ready=1, no LL writes later.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types for the register-file write-back arbiter.
//   wb_req_t       : one write-back request (destination register + value)
//   wb_arb_state_e : arbiter FSM states
//   REG_X0         : hard-wired zero register, never written
package wb_pkg;

  localparam int unsigned WB_XLEN = 32;
  localparam int unsigned RD_W    = 5;

  localparam logic [RD_W-1:0] REG_X0 = 5'd0;

  typedef struct packed {
    logic [RD_W-1:0]    rd;
    logic [WB_XLEN-1:0] data;
  } wb_req_t;

  typedef enum logic [0:0] {
    PIPE_PRIO = 1'b0,
    FORCE_LL  = 1'b1
  } wb_arb_state_e;

endpackage

// File: rtl/wb_ll_fifo.sv
// Synchronous FIFO holding long-latency write-back results.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (pointers/count cleared)
//   push, din   : enqueue din when push and not full
//   pop, dout   : dequeue head when pop and not empty; dout shows current head
//   full, empty : occupancy flags decoded from the registered count
// No bypass: an entry written this cycle is visible on dout from the next cycle.
module wb_ll_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  wb_req_t din,
  input  logic    pop,
  output wb_req_t dout,
  output logic    full,
  output logic    empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  wb_req_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter between the MEM/WB pipe result and the
// long-latency (LL) result path, with LL buffering and starvation guard.
// Ports:
//   clk, rst_n                     : clock, asynchronous active-low reset
//   pipe_valid/pipe_rd/pipe_data   : in-order MEM/WB write request
//   pipe_stall                     : MEM/WB must hold (request not consumed)
//   ll_valid/ll_rd/ll_data         : LL result offer
//   ll_ready                       : LL result accepted when ll_valid & ll_ready
//   rf_we/rf_rd/rf_wdata           : registered register-file write
// Optional (macro WB_ARB_FWD_EN):
//   fwd_valid/fwd_rd/fwd_data      : same-cycle mirror of the rf write for EX forwarding
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned XLEN       = WB_XLEN,
  parameter int unsigned LL_DEPTH   = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pipe_valid,
  input  logic [4:0]      pipe_rd,
  input  logic [XLEN-1:0] pipe_data,
  output logic            pipe_stall,
  input  logic            ll_valid,
  input  logic [4:0]      ll_rd,
  input  logic [XLEN-1:0] ll_data,
  output logic            ll_ready,
  output logic            rf_we,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_wdata
`ifdef WB_ARB_FWD_EN
  ,
  output logic            fwd_valid,
  output logic [4:0]      fwd_rd,
  output logic [XLEN-1:0] fwd_data
`endif
);

  localparam int unsigned SC_W = $clog2(STARVE_MAX + 1);

  wb_arb_state_e   state;
  wb_arb_state_e   state_nxt;
  logic [SC_W-1:0] starve_cnt;
  logic [SC_W-1:0] starve_nxt;

  logic    grant_pipe;
  logic    grant_ll;
  logic    wr_en;
  logic    ll_full;
  logic    ll_empty;
  logic    ll_push;
  wb_req_t ll_in;
  wb_req_t ll_head;
  wb_req_t pipe_req;
  wb_req_t win;

  // LL result buffer
  assign ll_ready = ~ll_full;
  assign ll_push  = ll_valid & ll_ready;
  assign ll_in    = '{rd: ll_rd, data: ll_data};

  wb_ll_fifo #(
    .DEPTH (LL_DEPTH)
  ) u_ll_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (ll_push),
    .din   (ll_in),
    .pop   (grant_ll),
    .dout  (ll_head),
    .full  (ll_full),
    .empty (ll_empty)
  );

  // FSM state and starvation counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= PIPE_PRIO;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  // Next-state, grants and stall; stall never depends on ll_* inputs.
  always_comb begin
    state_nxt  = state;
    starve_nxt = starve_cnt;
    grant_pipe = 1'b0;
    grant_ll   = 1'b0;
    pipe_stall = 1'b0;
    unique case (state)
      PIPE_PRIO: begin
        if (pipe_valid)     grant_pipe = 1'b1;
        else if (!ll_empty) grant_ll   = 1'b1;

        if (grant_ll || ll_empty) begin
          starve_nxt = '0;
        end else begin
          // pipe won while the LL head was waiting
          starve_nxt = starve_cnt + SC_W'(1);
          if (starve_nxt >= SC_W'(STARVE_MAX)) state_nxt = FORCE_LL;
        end
      end
      FORCE_LL: begin
        // only entered with a waiting LL head, so the pop is always valid
        grant_ll   = 1'b1;
        pipe_stall = pipe_valid;
        state_nxt  = PIPE_PRIO;
        starve_nxt = '0;
      end
      default: begin
        state_nxt  = PIPE_PRIO;
        starve_nxt = '0;
      end
    endcase
  end

  // Grant mux; x0 grants are consumed but never written.
  assign pipe_req = '{rd: pipe_rd, data: pipe_data};
  assign win      = grant_pipe ? pipe_req : ll_head;
  assign wr_en    = (grant_pipe | grant_ll) & (win.rd != REG_X0);

  // Registered register-file write; address/data hold when nothing is written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_rd    <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= wr_en;
      if (wr_en) begin
        rf_rd    <= win.rd;
        rf_wdata <= win.data;
      end
    end
  end

`ifdef WB_ARB_FWD_EN
  // Forwarding mirror of the write port
  assign fwd_valid = rf_we & (rf_rd != REG_X0);
  assign fwd_rd    = rf_rd;
  assign fwd_data  = rf_wdata;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned LL_DEPTH   = 2;
  localparam int unsigned STARVE_MAX = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            pipe_valid = 1'b0;
  logic [4:0]      pipe_rd = '0;
  logic [XLEN-1:0] pipe_data = '0;
  logic            pipe_stall;
  logic            ll_valid = 1'b0;
  logic [4:0]      ll_rd = '0;
  logic [XLEN-1:0] ll_data = '0;
  logic            ll_ready;
  logic            rf_we;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_wdata;
`ifdef WB_ARB_FWD_EN
  logic            fwd_valid;
  logic [4:0]      fwd_rd;
  logic [XLEN-1:0] fwd_data;
`endif

  always #5 clk = ~clk;

  wb_port_arbiter #(
    .XLEN       (XLEN),
    .LL_DEPTH   (LL_DEPTH),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pipe_valid (pipe_valid),
    .pipe_rd    (pipe_rd),
    .pipe_data  (pipe_data),
    .pipe_stall (pipe_stall),
    .ll_valid   (ll_valid),
    .ll_rd      (ll_rd),
    .ll_data    (ll_data),
    .ll_ready   (ll_ready),
    .rf_we      (rf_we),
    .rf_rd      (rf_rd),
    .rf_wdata   (rf_wdata)
`ifdef WB_ARB_FWD_EN
    ,
    .fwd_valid  (fwd_valid),
    .fwd_rd     (fwd_rd),
    .fwd_data   (fwd_data)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: queue of waiting LL results, a count of pipe wins
  // while the oldest LL result waits, and a pending "LL must go next" flag.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        m_q[$];
  int          m_starve = 0;
  bit          m_force = 0;
  logic        m_we = 1'b0;
  logic [4:0]  m_rd = '0;
  logic [31:0] m_data = '0;
  ent_t        w;
  bit          have;
  int          depth_before;

  int wr_cnt[32];
  int n105 = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_q.delete();
      m_starve = 0;
      m_force  = 0;
      m_we     = 1'b0;
      m_rd     = '0;
      m_data   = '0;
    end
    check("rf_we", 32'(rf_we), 32'(m_we));
    check("rf_rd", 32'(rf_rd), 32'(m_rd));
    check("rf_wdata", rf_wdata, m_data);
    check("ll_ready", 32'(ll_ready), 32'(m_q.size() < int'(LL_DEPTH)));
    check("pipe_stall", 32'(pipe_stall), 32'(m_force && pipe_valid));
    if (rf_we) begin
      wr_cnt[rf_rd]++;
      if (rf_wdata == 32'd105) n105++;
    end
    if (rst_n) begin
      depth_before = m_q.size();
      have = 0;
      if (m_force) begin
        if (depth_before != 0) begin w = m_q.pop_front(); have = 1; end
      end else if (pipe_valid) begin
        w.rd = pipe_rd; w.data = pipe_data; have = 1;
      end else if (depth_before != 0) begin
        w = m_q.pop_front(); have = 1;
      end
      if (m_force) begin
        m_force  = 0;
        m_starve = 0;
      end else if (pipe_valid && depth_before != 0) begin
        m_starve++;
        if (m_starve >= int'(STARVE_MAX)) begin m_force = 1; m_starve = 0; end
      end else begin
        m_starve = 0;
      end
      m_we = have && (w.rd != 5'd0);
      if (m_we) begin m_rd = w.rd; m_data = w.data; end
      if (ll_valid && depth_before < int'(LL_DEPTH)) begin
        w.rd = ll_rd; w.data = ll_data;
        m_q.push_back(w);
      end
    end
  end

  task automatic drive(input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
    @(posedge clk);
    #2;
    pipe_valid = pv; pipe_rd = prd; pipe_data = pd;
    ll_valid = lv; ll_rd = lrd; ll_data = ld;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  bit accepted;

  initial begin
    for (int i = 0; i < 32; i++) wr_cnt[i] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_rf_we", 32'(rf_we), 32'd0);
    check("reset_rf_rd", 32'(rf_rd), 32'd0);
    check("reset_rf_wdata", rf_wdata, 32'd0);
    check("reset_ll_ready", 32'(ll_ready), 32'd1);
    check("reset_pipe_stall", 32'(pipe_stall), 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;

    // pipe only
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    check("pipe_we", 32'(rf_we), 32'd1);
    check("pipe_rd", 32'(rf_rd), 32'd5);
    check("pipe_data", rf_wdata, 32'hDEADBEEF);

    // x0 write is consumed but suppressed
    drive(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    check("x0_stall", 32'(pipe_stall), 32'd0);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    check("x0_we", 32'(rf_we), 32'd0);

    // LL on idle pipe: two edges from offer to write
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h55);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    check("ll_lat_early", 32'(rf_we), 32'd0);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    check("ll_lat_we", 32'(rf_we), 32'd1);
    check("ll_lat_rd", 32'(rf_rd), 32'd7);
    check("ll_lat_data", rf_wdata, 32'h55);

    // LL x0 result followed by a real one
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hAAAA);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd11, 32'hBBBB);
    idle(4);

    // starvation guard
    n105 = 0;
    drive(1'b1, 5'd1, 32'd100, 1'b1, 5'd9, 32'h99);
    for (int k = 1; k <= 4; k++) drive(1'b1, 5'd1, 32'(100 + k), 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    check("starve_no_stall_yet", 32'(pipe_stall), 32'd0);
    drive(1'b1, 5'd1, 32'd105, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    check("starve_stall", 32'(pipe_stall), 32'd1);
    check("starve_prev_data", rf_wdata, 32'd104);
    drive(1'b1, 5'd1, 32'd105, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    check("starve_resume", 32'(pipe_stall), 32'd0);
    check("starve_ll_rd", 32'(rf_rd), 32'd9);
    check("starve_ll_data", rf_wdata, 32'h99);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    check("starve_held_data", rf_wdata, 32'd105);
    idle(2);
    check("starve_held_once", 32'(n105), 32'd1);

    // FIFO full under saturating pipe
    for (int i = 0; i < 32; i++) wr_cnt[i] = 0;
    drive(1'b1, 5'd2, 32'd200, 1'b1, 5'd20, 32'hA0);
    drive(1'b1, 5'd2, 32'd201, 1'b1, 5'd21, 32'hA1);
    drive(1'b1, 5'd2, 32'd202, 1'b1, 5'd22, 32'hA2);
    @(negedge clk);
    check("full_not_ready", 32'(ll_ready), 32'd0);
    accepted = 0;
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 5'd2, 32'(300 + k), 1'b1, 5'd22, 32'hA2);
      @(negedge clk);
      if (ll_ready) begin accepted = 1; break; end
    end
    check("full_third_accepted", 32'(accepted), 32'd1);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    idle(8);
    check("full_once_20", 32'(wr_cnt[20]), 32'd1);
    check("full_once_21", 32'(wr_cnt[21]), 32'd1);
    check("full_once_22", 32'(wr_cnt[22]), 32'd1);

    // reset with two buffered LL results and a write in flight
    drive(1'b1, 5'd3, 32'h300, 1'b1, 5'd25, 32'h250);
    drive(1'b1, 5'd3, 32'h301, 1'b1, 5'd26, 32'h260);
    @(negedge clk);
    check("rst_pre_we", 32'(rf_we), 32'd1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    pipe_valid = 1'b0; ll_valid = 1'b0;
    @(negedge clk);
    check("rst_we_drop", 32'(rf_we), 32'd0);
    check("rst_ll_ready", 32'(ll_ready), 32'd1);
    @(posedge clk); #2 rst_n = 1'b1;
    idle(6);
    check("rst_no_ll_25", 32'(wr_cnt[25]), 32'd0);
    check("rst_no_ll_26", 32'(wr_cnt[26]), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
